// File: rtl/ram8_bank.sv
// ram8_bank: 8-word x WIDTH-bit register bank with a one-hot write decode,
// registered reads with a valid flag, and a sequential clear engine that
// zeroes one word per cycle.
// Optional build macro RAM8_BANK_BYPASS_EN: when defined, a same-cycle
// load+read at the (shared) address forwards the incoming write data to out
// instead of returning the stored value.
module ram8_bank #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   input  logic              rd_en,
   input  logic              clr,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              busy,
   output logic [7:0]        written
);

   localparam int DEPTH = 8;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]        state_q,     state_d;
   logic [ADDR_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0]  out_q,       out_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q,      busy_d;
   logic [7:0]        written_q,   written_d;
   logic [WIDTH-1:0]  mem_q [0:DEPTH-1];
   logic [WIDTH-1:0]  mem_d [0:DEPTH-1];

   logic [7:0]        wr_sel_s;
   logic [7:0]        clr_sel_s;
   logic [WIDTH-1:0]  rd_data_s;

   // One-hot decodes for the write port and the clear engine.
   always_comb begin
      wr_sel_s  = 8'd1 << address;
      clr_sel_s = 8'd1 << cnt_q;
   end

   // Read data source; same-cycle load forwards the write data when enabled.
   always_comb begin
`ifdef RAM8_BANK_BYPASS_EN
      if (load) begin
         rd_data_s = in;
      end else begin
         rd_data_s = mem_q[address];
      end
`else
      rd_data_s = mem_q[address];
`endif
   end

   // Next-state logic: IDLE services clr > load/read, CLEAR walks the bank.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      written_d   = written_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      case (state_q)
         IDLE: begin
            if (clr) begin
               // Accepting a clear drops any load/read in the same cycle.
               state_d = CLEAR;
               cnt_d   = {ADDR_W{1'b0}};
               busy_d  = 1'b1;
            end else begin
               busy_d = 1'b0;
               if (load) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (wr_sel_s[i]) begin
                        mem_d[i] = in;
                     end else begin
                        mem_d[i] = mem_q[i];
                     end
                  end
                  written_d = written_q | wr_sel_s;
               end else begin
                  written_d = written_q;
               end
               if (rd_en) begin
                  out_d       = rd_data_s;
                  out_valid_d = 1'b1;
               end else begin
                  out_d       = out_q;
                  out_valid_d = 1'b0;
               end
            end
         end
         CLEAR: begin
            for (int i = 0; i < DEPTH; i++) begin
               if (clr_sel_s[i]) begin
                  mem_d[i] = {WIDTH{1'b0}};
               end else begin
                  mem_d[i] = mem_q[i];
               end
            end
            written_d = written_q & ~clr_sel_s;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}}) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = CLEAR;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {ADDR_W{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= {ADDR_W{1'b0}};
         out_q       <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         written_q   <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         written_q   <= written_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign written   = written_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
module tb_ram8_bank;

   logic        clk;
   logic        reset;
   logic [15:0] in_s;
   logic [2:0]  address_s;
   logic        load_s;
   logic        rd_en_s;
   logic        clr_s;
   logic [15:0] out_s;
   logic        out_valid_s;
   logic        busy_s;
   logic [7:0]  written_s;

   int pass_cnt;
   int check_cnt;

   ram8_bank #(.WIDTH(16), .ADDR_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_s),
      .address   (address_s),
      .load      (load_s),
      .rd_en     (rd_en_s),
      .clr       (clr_s),
      .out       (out_s),
      .out_valid (out_valid_s),
      .busy      (busy_s),
      .written   (written_s)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_s  = 1'b0;
      rd_en_s = 1'b0;
      clr_s   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      in_s = 16'h0000;
      address_s = 3'd0;
      tick();
      tick();
      check_cnt++;
      if (out_s !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", out_s); else pass_cnt++;
      check_cnt++;
      if (out_valid_s !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid_s); else pass_cnt++;
      check_cnt++;
      if (busy_s !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_s); else pass_cnt++;
      check_cnt++;
      if (written_s !== 8'h00) $display("FAIL reset_written got=%h exp=00", written_s); else pass_cnt++;
      reset = 1'b0;
      rd_en_s = 1'b1;
      address_s = 3'd5;
      tick();
      check_cnt++;
      if (out_s !== 16'h0000 || out_valid_s !== 1'b1 || written_s !== 8'h00)
         $display("FAIL reset_read5 got=%h/%b/%h exp=0000/1/00", out_s, out_valid_s, written_s);
      else pass_cnt++;
      idle_inputs();
      tick();
   endtask

   task automatic test_write_read();
      load_s = 1'b1; in_s = 16'hBEEF; address_s = 3'd3;
      tick();
      load_s = 1'b0; rd_en_s = 1'b1; address_s = 3'd3;
      tick();
      check_cnt++;
      if (out_s !== 16'hBEEF || out_valid_s !== 1'b1) $display("FAIL wr_rd3 got=%h/%b exp=beef/1", out_s, out_valid_s); else pass_cnt++;
      check_cnt++;
      if (written_s !== 8'h08) $display("FAIL wr_written got=%h exp=08", written_s); else pass_cnt++;
      address_s = 3'd4;
      tick();
      check_cnt++;
      if (out_s !== 16'h0000) $display("FAIL wr_rd4 got=%h exp=0000", out_s); else pass_cnt++;
      address_s = 3'd3;
      tick();
      rd_en_s = 1'b0;
      tick();
      check_cnt++;
      if (out_s !== 16'hBEEF || out_valid_s !== 1'b0) $display("FAIL rd_hold got=%h/%b exp=beef/0", out_s, out_valid_s); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) begin
         load_s = 1'b1; address_s = 3'(i); in_s = 16'h1111 * 16'(i + 1);
         tick();
      end
      load_s = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         rd_en_s = 1'b1; address_s = 3'(i);
         tick();
         exp = 16'h1111 * 16'(i + 1);
         check_cnt++;
         if (out_s !== exp || out_valid_s !== 1'b1)
            $display("FAIL b2b_rd%0d got=%h/%b exp=%h/1", i, out_s, out_valid_s, exp);
         else pass_cnt++;
      end
      rd_en_s = 1'b0;
      check_cnt++;
      if (written_s !== 8'hFF) $display("FAIL b2b_written got=%h exp=ff", written_s); else pass_cnt++;
      tick();
   endtask

   task automatic test_same_cycle();
      logic [15:0] exp;
      load_s = 1'b1; address_s = 3'd2; in_s = 16'hAAAA;
      tick();
      load_s = 1'b1; rd_en_s = 1'b1; address_s = 3'd2; in_s = 16'h1234;
      tick();
`ifdef RAM8_BANK_BYPASS_EN
      exp = 16'h1234;
`else
      exp = 16'hAAAA;
`endif
      check_cnt++;
      if (out_s !== exp || out_valid_s !== 1'b1) $display("FAIL same_cycle got=%h/%b exp=%h/1", out_s, out_valid_s, exp); else pass_cnt++;
      load_s = 1'b0; rd_en_s = 1'b1;
      tick();
      check_cnt++;
      if (out_s !== 16'h1234) $display("FAIL same_cycle_later got=%h exp=1234", out_s); else pass_cnt++;
      rd_en_s = 1'b0;
      tick();
   endtask

   task automatic test_clear();
      // Bank is full here; last read left out = 0x1234.
      clr_s = 1'b1; load_s = 1'b1; rd_en_s = 1'b1; in_s = 16'hFFFF; address_s = 3'd0;
      tick();
      clr_s = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check_cnt++;
         if (busy_s !== 1'b1 || out_valid_s !== 1'b0 || out_s !== 16'h1234)
            $display("FAIL clr_busy%0d got=%b/%b/%h exp=1/0/1234", k, busy_s, out_valid_s, out_s);
         else pass_cnt++;
         tick();
      end
      idle_inputs();
      check_cnt++;
      if (busy_s !== 1'b0) $display("FAIL clr_busy_end got=%b exp=0", busy_s); else pass_cnt++;
      check_cnt++;
      if (written_s !== 8'h00) $display("FAIL clr_written got=%h exp=00", written_s); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         rd_en_s = 1'b1; address_s = 3'(i);
         tick();
         check_cnt++;
         if (out_s !== 16'h0000 || out_valid_s !== 1'b1)
            $display("FAIL clr_rd%0d got=%h/%b exp=0000/1", i, out_s, out_valid_s);
         else pass_cnt++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_clear();
      load_s = 1'b1; address_s = 3'd5; in_s = 16'h5555;
      tick();
      address_s = 3'd1; in_s = 16'h1515;
      tick();
      load_s = 1'b0; rd_en_s = 1'b1; address_s = 3'd5;
      tick();
      rd_en_s = 1'b0;
      clr_s = 1'b1;
      tick();                 // first busy cycle
      clr_s = 1'b0;
      tick();
      tick();
      tick();                 // fourth busy cycle
      check_cnt++;
      if (busy_s !== 1'b1) $display("FAIL midclr_busy4 got=%b exp=1", busy_s); else pass_cnt++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_cnt++;
      if (busy_s !== 1'b0 || out_s !== 16'h0000 || out_valid_s !== 1'b0 || written_s !== 8'h00)
         $display("FAIL midclr_reset got=%b/%h/%b/%h exp=0/0000/0/00", busy_s, out_s, out_valid_s, written_s);
      else pass_cnt++;
      load_s = 1'b1; address_s = 3'd6; in_s = 16'h6666;
      tick();
      load_s = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_en_s = 1'b1; address_s = 3'(i);
         tick();
         check_cnt++;
         if (out_s !== ((i == 6) ? 16'h6666 : 16'h0000))
            $display("FAIL midclr_rd%0d got=%h exp=%h", i, out_s, (i == 6) ? 16'h6666 : 16'h0000);
         else pass_cnt++;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      pass_cnt = 0;
      check_cnt = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_same_cycle();
      test_clear();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
